// File: rtl/control_unit_if.sv
// control_unit_if: IR/CON inputs and all datapath
// control strobes driven by the mini-SRC control unit.
interface control_unit_if;
  logic [31:0] ir;
  logic        con_ff;
  logic        PCout;
  logic        Zlowout;
  logic        ZHighout;
  logic        HIout;
  logic        LOout;
  logic        InPortout;
  logic        MDRout;
  logic        Cout;
  logic        PCin;
  logic        IRin;
  logic        MARin;
  logic        MDRin;
  logic        Yin;
  logic        HIin;
  logic        LOin;
  logic        ZHIin;
  logic        ZLOin;
  logic        CONin;
  logic        outportin;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        IncPC;
  logic        Read;
  logic        Write;
  logic [4:0]  operation;
  logic        run;

  modport master (
    input  ir, con_ff,
    output PCout, Zlowout, ZHighout, HIout,
    output LOout, InPortout, MDRout, Cout,
    output PCin, IRin, MARin, MDRin, Yin,
    output HIin, LOin, ZHIin, ZLOin, CONin,
    output outportin,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output IncPC, Read, Write,
    output operation, run
  );

  modport slave (
    output ir, con_ff,
    input  PCout, Zlowout, ZHighout, HIout,
    input  LOout, InPortout, MDRout, Cout,
    input  PCin, IRin, MARin, MDRin, Yin,
    input  HIin, LOin, ZHIin, ZLOin, CONin,
    input  outportin,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  IncPC, Read, Write,
    input  operation, run
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for mini-SRC.
// Outputs are registered from the next state and IR.
module control_unit (
  input  logic            clk,
  input  logic            clr,
  input  logic            stop,
  control_unit_if.master  bus
);

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_DEC,
    S_E3, S_E4, S_E5, S_E6, S_E7, S_HALT
  } state_e;

  typedef struct packed {
    logic       PCout;
    logic       Zlowout;
    logic       ZHighout;
    logic       HIout;
    logic       LOout;
    logic       InPortout;
    logic       MDRout;
    logic       Cout;
    logic       PCin;
    logic       IRin;
    logic       MARin;
    logic       MDRin;
    logic       Yin;
    logic       HIin;
    logic       LOin;
    logic       ZHIin;
    logic       ZLOin;
    logic       CONin;
    logic       outportin;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       Rin;
    logic       Rout;
    logic       BAout;
    logic       IncPC;
    logic       Read;
    logic       Write;
    logic [4:0] operation;
    logic       run;
  } ctl_t;

  localparam logic [4:0] OP_ADD = 5'b00011;

  state_e state_q, state_d;
  state_e last;
  state_e fin;
  ctl_t   out_q, out_d;
  logic [4:0] op;
  logic   unused_ir;

  logic c_ld, c_ldi, c_st, c_alu3, c_imm;
  logic c_md, c_alu2, c_br, c_jr, c_jal;
  logic c_in, c_out, c_mfhi, c_mflo;
  logic c_nop, c_halt;

  assign op        = bus.ir[31:27];
  assign unused_ir = ^bus.ir[26:0];

  assign c_ld   = (op == 5'd0);
  assign c_ldi  = (op == 5'd1);
  assign c_st   = (op == 5'd2);
  assign c_alu3 = (op >= 5'd3) && (op <= 5'd11);
  assign c_imm  = (op >= 5'd12) && (op <= 5'd14);
  assign c_md   = (op == 5'd15) || (op == 5'd16);
  assign c_alu2 = (op == 5'd17) || (op == 5'd18);
  assign c_br   = (op == 5'd19);
  assign c_jr   = (op == 5'd20);
  assign c_jal  = (op == 5'd21);
  assign c_in   = (op == 5'd22);
  assign c_out  = (op == 5'd23);
  assign c_mfhi = (op == 5'd24);
  assign c_mflo = (op == 5'd25);
  assign c_nop  = (op == 5'd26) || (op[4:2] == 3'b111);
  assign c_halt = (op == 5'd27);

  assign fin = stop ? S_HALT : S_F0;

  // Final execute step of the decoded class
  always_comb begin
    last = S_DEC;
    unique case (1'b1)
      c_jr | c_in | c_out | c_mfhi | c_mflo:
        last = S_E3;
      c_jal | c_alu2:
        last = S_E4;
      c_alu3 | c_imm | c_ldi:
        last = S_E5;
      c_md | c_br:
        last = S_E6;
      c_ld | c_st:
        last = S_E7;
      default:
        last = S_DEC;
    endcase
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:  state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_DEC;
      S_DEC:
        if (c_halt)     state_d = S_HALT;
        else if (c_nop) state_d = fin;
        else            state_d = S_E3;
      S_E3:
        state_d = (last == S_E3) ? fin : S_E4;
      S_E4:
        state_d = (last == S_E4) ? fin : S_E5;
      S_E5:
        state_d = (last == S_E5) ? fin : S_E6;
      S_E6:
        state_d = (last == S_E6) ? fin : S_E7;
      S_E7:   state_d = fin;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Control word for the state being entered
  always_comb begin
    out_d     = '0;
    out_d.run = (state_d != S_RST) &&
                (state_d != S_HALT);
    unique case (state_d)
      S_F0: begin
        out_d.PCout = 1'b1;
        out_d.MARin = 1'b1;
        out_d.IncPC = 1'b1;
        out_d.ZLOin = 1'b1;
      end
      S_F1: begin
        out_d.Zlowout = 1'b1;
        out_d.PCin    = 1'b1;
        out_d.Read    = 1'b1;
        out_d.MDRin   = 1'b1;
      end
      S_F2: begin
        out_d.MDRout = 1'b1;
        out_d.IRin   = 1'b1;
      end
      S_E3: begin
        unique case (1'b1)
          c_alu3 | c_imm: begin
            out_d.Grb  = 1'b1;
            out_d.Rout = 1'b1;
            out_d.Yin  = 1'b1;
          end
          c_alu2: begin
            out_d.Grb       = 1'b1;
            out_d.Rout      = 1'b1;
            out_d.operation = op;
            out_d.ZLOin     = 1'b1;
          end
          c_md: begin
            out_d.Gra  = 1'b1;
            out_d.Rout = 1'b1;
            out_d.Yin  = 1'b1;
          end
          c_ld | c_ldi | c_st: begin
            out_d.Grb   = 1'b1;
            out_d.BAout = 1'b1;
            out_d.Yin   = 1'b1;
          end
          c_br: begin
            out_d.Gra   = 1'b1;
            out_d.Rout  = 1'b1;
            out_d.CONin = 1'b1;
          end
          c_jr: begin
            out_d.Gra  = 1'b1;
            out_d.Rout = 1'b1;
            out_d.PCin = 1'b1;
          end
          c_jal: begin
            out_d.PCout = 1'b1;
            out_d.Grb   = 1'b1;
            out_d.Rin   = 1'b1;
          end
          c_in: begin
            out_d.InPortout = 1'b1;
            out_d.Gra       = 1'b1;
            out_d.Rin       = 1'b1;
          end
          c_out: begin
            out_d.Gra       = 1'b1;
            out_d.Rout      = 1'b1;
            out_d.outportin = 1'b1;
          end
          c_mfhi: begin
            out_d.HIout = 1'b1;
            out_d.Gra   = 1'b1;
            out_d.Rin   = 1'b1;
          end
          c_mflo: begin
            out_d.LOout = 1'b1;
            out_d.Gra   = 1'b1;
            out_d.Rin   = 1'b1;
          end
          default: ;
        endcase
      end
      S_E4: begin
        unique case (1'b1)
          c_alu3: begin
            out_d.Grc       = 1'b1;
            out_d.Rout      = 1'b1;
            out_d.operation = op;
            out_d.ZLOin     = 1'b1;
          end
          c_alu2: begin
            out_d.Zlowout = 1'b1;
            out_d.Gra     = 1'b1;
            out_d.Rin     = 1'b1;
          end
          c_imm: begin
            out_d.Cout      = 1'b1;
            out_d.operation = op;
            out_d.ZLOin     = 1'b1;
          end
          c_md: begin
            out_d.Grb       = 1'b1;
            out_d.Rout      = 1'b1;
            out_d.operation = op;
            out_d.ZHIin     = 1'b1;
            out_d.ZLOin     = 1'b1;
          end
          c_ld | c_ldi | c_st: begin
            out_d.Cout      = 1'b1;
            out_d.operation = OP_ADD;
            out_d.ZLOin     = 1'b1;
          end
          c_br: begin
            out_d.PCout = 1'b1;
            out_d.Yin   = 1'b1;
          end
          c_jal: begin
            out_d.Gra  = 1'b1;
            out_d.Rout = 1'b1;
            out_d.PCin = 1'b1;
          end
          default: ;
        endcase
      end
      S_E5: begin
        unique case (1'b1)
          c_alu3 | c_imm | c_ldi: begin
            out_d.Zlowout = 1'b1;
            out_d.Gra     = 1'b1;
            out_d.Rin     = 1'b1;
          end
          c_md: begin
            out_d.Zlowout = 1'b1;
            out_d.LOin    = 1'b1;
          end
          c_ld | c_st: begin
            out_d.Zlowout = 1'b1;
            out_d.MARin   = 1'b1;
          end
          c_br: begin
            out_d.Cout      = 1'b1;
            out_d.operation = OP_ADD;
            out_d.ZLOin     = 1'b1;
          end
          default: ;
        endcase
      end
      S_E6: begin
        unique case (1'b1)
          c_md: begin
            out_d.ZHighout = 1'b1;
            out_d.HIin     = 1'b1;
          end
          c_ld: begin
            out_d.Read  = 1'b1;
            out_d.MDRin = 1'b1;
          end
          c_st: begin
            out_d.Gra   = 1'b1;
            out_d.Rout  = 1'b1;
            out_d.MDRin = 1'b1;
          end
          c_br: begin
            out_d.Zlowout = bus.con_ff;
            out_d.PCin    = bus.con_ff;
          end
          default: ;
        endcase
      end
      S_E7: begin
        unique case (1'b1)
          c_ld: begin
            out_d.MDRout = 1'b1;
            out_d.Gra    = 1'b1;
            out_d.Rin    = 1'b1;
          end
          c_st:
            out_d.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State and registered control word
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_RST;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign bus.PCout     = out_q.PCout;
  assign bus.Zlowout   = out_q.Zlowout;
  assign bus.ZHighout  = out_q.ZHighout;
  assign bus.HIout     = out_q.HIout;
  assign bus.LOout     = out_q.LOout;
  assign bus.InPortout = out_q.InPortout;
  assign bus.MDRout    = out_q.MDRout;
  assign bus.Cout      = out_q.Cout;
  assign bus.PCin      = out_q.PCin;
  assign bus.IRin      = out_q.IRin;
  assign bus.MARin     = out_q.MARin;
  assign bus.MDRin     = out_q.MDRin;
  assign bus.Yin       = out_q.Yin;
  assign bus.HIin      = out_q.HIin;
  assign bus.LOin      = out_q.LOin;
  assign bus.ZHIin     = out_q.ZHIin;
  assign bus.ZLOin     = out_q.ZLOin;
  assign bus.CONin     = out_q.CONin;
  assign bus.outportin = out_q.outportin;
  assign bus.Gra       = out_q.Gra;
  assign bus.Grb       = out_q.Grb;
  assign bus.Grc       = out_q.Grc;
  assign bus.Rin       = out_q.Rin;
  assign bus.Rout      = out_q.Rout;
  assign bus.BAout     = out_q.BAout;
  assign bus.IncPC     = out_q.IncPC;
  assign bus.Read      = out_q.Read;
  assign bus.Write     = out_q.Write;
  assign bus.operation = out_q.operation;
  assign bus.run       = out_q.run;

endmodule
